// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour types for the bitmap overlay blocks.
// Window origins are derived from sync + back porch of each supported mode.
package vga_pkg;

  localparam int H_SYNC_640 = 96;
  localparam int H_BP_640   = 48;
  localparam int V_SYNC_640 = 2;
  localparam int V_BP_640   = 33;

  localparam int H_SYNC_800 = 128;
  localparam int H_BP_800   = 88;
  localparam int V_SYNC_800 = 4;
  localparam int V_BP_800   = 23;

  // c1/c2 value one before the first visible column/row of each mode
  localparam int X_START_640 = H_SYNC_640 + H_BP_640;
  localparam int Y_START_640 = V_SYNC_640 + V_BP_640;
  localparam int X_START_800 = H_SYNC_800 + H_BP_800;
  localparam int Y_START_800 = V_SYNC_800 + V_BP_800;

  typedef logic [2:0] rgb3_t;

  localparam rgb3_t RGB_BLACK = 3'b000;

  // Per-pixel tag travelling beside the ROM access
  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } pix_tag_t;

endpackage

// File: rtl/vga_win_map.sv
// Window hit test and screen-to-bitmap coordinate mapping (purely combinational).
// All arithmetic is 12 bits wide so X_START + scaled width cannot wrap.
module vga_win_map
  import vga_pkg::*;
#(
  parameter int WIN_W      = 128,
  parameter int WIN_H      = 128,
  parameter int X_START    = X_START_800,
  parameter int Y_START    = Y_START_800,
  parameter int SCALE_LOG2 = 0,
  parameter int XW         = 7,
  parameter int YW         = 7
) (
  input  logic [10:0]   c1,
  input  logic [10:0]   c2,
  input  logic          en,
  output logic          hit,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  localparam logic [11:0] X_LO = 12'(X_START);
  localparam logic [11:0] X_HI = 12'(X_START + (WIN_W << SCALE_LOG2));
  localparam logic [11:0] Y_LO = 12'(Y_START);
  localparam logic [11:0] Y_HI = 12'(Y_START + (WIN_H << SCALE_LOG2));

  logic [11:0] c1_w;
  logic [11:0] c2_w;
  logic [11:0] dx;
  logic [11:0] dy;

  always_comb begin
    c1_w = {1'b0, c1};
    c2_w = {1'b0, c2};
    dx   = c1_w - X_LO - 12'd1;
    dy   = c2_w - Y_LO - 12'd1;
    x    = XW'(dx >> SCALE_LOG2);
    y    = YW'(dy >> SCALE_LOG2);
    hit  = en && (c1_w > X_LO) && (c1_w <= X_HI) &&
           (c2_w > Y_LO) && (c2_w <= Y_HI);
  end

endmodule

// File: rtl/vga_bitmap_window.sv
// 1-bpp bitmap overlay: maps the sync counters into a scaled window, fetches the
// packed pixel byte from a synchronous ROM and colours it, 3 clk from c1/c2 to rgb.
module vga_bitmap_window
  import vga_pkg::*;
#(
  parameter int WIN_W      = 128,
  parameter int WIN_H      = 128,
  parameter int X_START    = 216,
  parameter int Y_START    = 27,
  parameter int SCALE_LOG2 = 0,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       c1,
  input  logic [10:0]       c2,
  input  logic              enable,
  input  logic              invert,
  input  logic [2:0]        fg_rgb,
  input  logic [2:0]        bg_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [2:0]        rgb,
  output logic              pix_valid
);

  localparam int XW = $clog2(WIN_W);
  localparam int YW = (WIN_H > 1) ? $clog2(WIN_H) : 1;

  logic          en_f;
  logic          inv_f;
  logic          frame_start;

  logic          hit_map;
  logic [XW-1:0] x_map;
  logic [YW-1:0] y_map;

  logic          hit0;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;

  logic [ADDR_W-1:0] addr_next;
  pix_tag_t          tag1;
  pix_tag_t          tag2;

  assign frame_start = (c1 == 11'd0) && (c2 == 11'd0);

  // Display controls change only at frame start so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_f  <= 1'b0;
      inv_f <= 1'b0;
    end else if (frame_start) begin
      en_f  <= enable;
      inv_f <= invert;
    end
  end

  vga_win_map #(
    .WIN_W      (WIN_W),
    .WIN_H      (WIN_H),
    .X_START    (X_START),
    .Y_START    (Y_START),
    .SCALE_LOG2 (SCALE_LOG2),
    .XW         (XW),
    .YW         (YW)
  ) u_map (
    .c1  (c1),
    .c2  (c2),
    .en  (en_f),
    .hit (hit_map),
    .x   (x_map),
    .y   (y_map)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit0 <= 1'b0;
      x0   <= '0;
      y0   <= '0;
    end else begin
      hit0 <= hit_map;
      x0   <= x_map;
      y0   <= y_map;
    end
  end

  // Row stride is WIN_W/8 bytes; a single-row bitmap has no row term at all
  always_comb begin
    addr_next = ADDR_W'(x0 >> 3);
    if (WIN_H > 1)
      addr_next = addr_next + (ADDR_W'(y0) << (XW - 3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      tag1     <= '0;
      tag2     <= '0;
    end else begin
      rom_addr <= addr_next;
      tag1.hit <= hit0;
      tag1.idx <= x0[2:0];
      tag2     <= tag1;
    end
  end

  // Output is combinational on registered tags so reset blanks it at once
  always_comb begin
    rgb       = RGB_BLACK;
    pix_valid = tag2.hit;
    if (tag2.hit)
      rgb = (rom_data[tag2.idx] ^ inv_f) ? fg_rgb : bg_rgb;
  end

endmodule

// File: doc/vga_bitmap_window.md
VGA_BITMAP_WINDOW -- requirements
Module: vga_bitmap_window

Interface
REQ-001 Parameter WIN_W, default 128: bitmap width in source pixels; power of two, 8 to 512.
REQ-002 Parameter WIN_H, default 128: bitmap height in source pixels; power of two, 1 to 512.
REQ-003 Parameter X_START, default 216: c1 value one before the first window column (sync + back porch + offset).
REQ-004 Parameter Y_START, default 27: c2 value one before the first window row.
REQ-005 Parameter SCALE_LOG2, default 0: integer upscale factor 2^SCALE_LOG2 in both axes; legal values 0 to 2.
REQ-006 Parameter ADDR_W, default 11: ROM address width; equals log2(WIN_W*WIN_H/8).
REQ-007 clk  in  1  pixel clock; reset is rst_n, asynchronous, active-low; clock is clk.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 c1  in  11  horizontal pixel counter from the sync generator.
REQ-010 c2  in  11  vertical line counter from the sync generator.
REQ-011 enable  in  1  display request; only takes effect at frame start.
REQ-012 invert  in  1  swap foreground and background; only takes effect at frame start.
REQ-013 fg_rgb  in  3  colour for bitmap bit = 1.
REQ-014 bg_rgb  in  3  colour for bitmap bit = 0 inside the window.
REQ-015 rom_addr  out  ADDR_W  synchronous ROM address, 8 pixels per byte.
REQ-016 rom_data  in  8  ROM byte, valid exactly 1 clk after rom_addr.
REQ-017 rgb  out  3  pixel colour; 3'b000 outside the window or when disabled.
REQ-018 pix_valid  out  1  high while rgb carries a window pixel.

Function
REQ-019 The block SHALL accept one new (c1,c2) pair every clk; throughput is 1 pixel/clk, with no multi-cycle loop.
REQ-020 Stage 0: window hit SHALL be X_START < c1 <= X_START + (WIN_W<<SCALE_LOG2) AND Y_START < c2 <= Y_START + (WIN_H<<SCALE_LOG2), with comparisons 12 bits wide so the sums do not overflow.
REQ-021 Stage 0: source x = (c1-X_START-1)>>SCALE_LOG2 and y = (c2-Y_START-1)>>SCALE_LOG2, truncated to log2(WIN_W) and log2(WIN_H) bits.
REQ-022 Stage 1: rom_addr SHALL register y*(WIN_W/8) + (x>>3) as a shift-add; bit index = x[2:0]; hit SHALL be piped alongside.
REQ-023 Stage 2: ROM read cycle; index and hit SHALL be delayed 1 clk.
REQ-024 Stage 3: rgb = hit ? (rom_data[index] ^ inv_f ? fg_rgb : bg_rgb) : 3'b000; pix_valid = hit.
REQ-025 Bit order: rom_data[0] is the leftmost pixel of each byte.
REQ-026 Total latency from c1/c2 to rgb/pix_valid SHALL be exactly 3 clk.
REQ-027 en_f and inv_f SHALL load from enable and invert only in the cycle when c1==0 and c2==0; they hold for the whole frame, preventing tearing.
REQ-028 When en_f==0, hit SHALL be forced to 0 in stage 0; rom_addr continues to update.
REQ-029 fg_rgb and bg_rgb SHALL be sampled at stage 3 with no frame latching.
REQ-030 The last column and the last row of the window SHALL map to x=WIN_W-1 and y=WIN_H-1, and rom_addr SHALL never exceed 2^ADDR_W-1.

Reset
REQ-031 On rst_n low: rom_addr=0, rgb=3'b000, pix_valid=0, all pipeline hit bits=0, en_f=0, inv_f=0.
REQ-032 Reset asserted mid-line SHALL blank the output immediately; after release, output stays blank until the next frame start loads en_f.

Structure
REQ-033 A shared package vga_pkg SHALL hold the 640x480/800x600 timing constants (sync, back porch) used to derive X_START and Y_START, plus an RGB3 colour typedef.
REQ-034 The block is a single module; the window compare and coordinate mapping MAY be a sub-module named vga_win_map.

Verification
REQ-035 Defaults, enable=1, all-ones ROM, fg=3'b111: c1=217,c2=28 -> rgb=3'b111 and pix_valid=1 three clk later; c1=216 -> rgb=0.
REQ-036 Defaults: c1=344,c2=155 -> rom_addr=2047 two clk later, index=7; c1=345 -> pix_valid=0.
REQ-037 SCALE_LOG2=1: c1=217 and c1=218 -> same rom_addr and index; c1=472 -> x=127; c1=473 -> outside.
REQ-038 enable toggled 1->0 mid-frame: output unchanged until c1=0,c2=0, then the whole window is black.
REQ-039 invert=1 latched, ROM byte 8'h01 at addr 0: c1=217,c2=28 -> bg_rgb; c1=218 -> fg_rgb.
REQ-040 rst_n pulsed at c1=300,c2=60 -> rgb=0 and pix_valid=0 asynchronously; output stays blank until the next frame.
